// File: rtl/keypad_calculator_top.sv
// 16-bit signed keypad calculator: 4x4 matrix scan/debounce front end feeding
// an operand-entry / arithmetic controller that drives a two's-complement display.

module keypad_input_ctrl #(
  parameter int SCAN_HOLD = 4,
  parameter int DEBOUNCE  = 2
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       key_valid_o,
  output logic [3:0] key_o
);
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_DECODE   = 2'd2,
    ST_HELD     = 2'd3
  } ic_state_t;

  ic_state_t  state;
  logic [1:0] col_q;
  logic [3:0] col_oh_q;
  logic [7:0] hold_q;
  logic [7:0] db_q;
  logic [3:0] row_q;
  logic [3:0] key_q;

  // Several rows low at once resolve to the lowest-numbered row.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0]) return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else return 2'd3;
  endfunction

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state    <= ST_SCAN;
      col_q    <= 2'd0;
      col_oh_q <= 4'b1110;
      hold_q   <= '0;
      db_q     <= '0;
      row_q    <= 4'hF;
      key_q    <= 4'd0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (row_i != 4'hF) begin
            state <= ST_DEBOUNCE;
            row_q <= row_i;
            db_q  <= '0;
          end else if (hold_q == 8'(SCAN_HOLD - 1)) begin
            hold_q   <= '0;
            col_q    <= col_q + 2'd1;
            col_oh_q <= ~(4'b0001 << (col_q + 2'd1));
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_i == 4'hF) begin
            state  <= ST_SCAN;
            hold_q <= '0;
          end else if (row_i != row_q) begin
            row_q <= row_i;
            db_q  <= '0;
          end else if (db_q == 8'(DEBOUNCE - 1)) begin
            state <= ST_DECODE;
          end else begin
            db_q <= db_q + 8'd1;
          end
        end
        ST_DECODE: begin
          key_q <= {low_row(row_q), col_q};
          state <= ST_HELD;
        end
        ST_HELD: begin
          if (row_i == 4'hF) begin
            state  <= ST_SCAN;
            hold_q <= '0;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

  assign col_o       = col_oh_q;
  assign key_valid_o = (state == ST_HELD);
  assign key_o       = key_q;
endmodule

module keypad_gencon #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              key_valid_i,
  input  logic [3:0]        key_i,
  output logic [DATA_W-1:0] display_o,
  output logic              complete_o
);
  localparam logic [3:0] K_ADD = 4'd3;
  localparam logic [3:0] K_SUB = 4'd7;
  localparam logic [3:0] K_MUL = 4'd11;
  localparam logic [3:0] K_EQ  = 4'd12;
  localparam logic [3:0] K_CLR = 4'd14;
  localparam logic [3:0] K_NEG = 4'd15;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, DONE} gst_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

  gst_t                      gst_q;
  op_t                       op_q;
  logic [DATA_W-1:0]         a_mag_q, b_mag_q;
  logic                      a_neg_q, b_neg_q, a_dig_q, b_dig_q;
  logic                      key_read;
  logic signed [DATA_W-1:0]  display_q;
  logic                      complete_q;

  logic                      is_dig, is_op;
  logic [3:0]                dig;
  op_t                       key_op;
  logic [DATA_W-1:0]         a_app, b_app;
  logic signed [DATA_W-1:0]  result;

  function automatic logic [3:0] digit_val(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2:  return k + 4'd1;
      4'd4, 4'd5, 4'd6:  return k;
      4'd8, 4'd9, 4'd10: return k - 4'd1;
      default:           return 4'd0;
    endcase
  endfunction

  // Decimal shift-in wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] append_digit(input logic [DATA_W-1:0] mag,
                                                      input logic [3:0] d);
    return mag * DATA_W'(10) + DATA_W'(d);
  endfunction

  function automatic logic signed [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                          input logic neg);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic signed [DATA_W-1:0] alu(input op_t op,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] prod;
    prod = a * b;
    case (op)
      OP_SUB:  return a - b;
      OP_MUL:  return prod[DATA_W-1:0];
      default: return a + b;
    endcase
  endfunction

  always_comb begin
    is_dig = (key_i inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd13});
    is_op  = (key_i == K_ADD) || (key_i == K_SUB) || (key_i == K_MUL);
    dig    = digit_val(key_i);
    case (key_i)
      K_SUB:   key_op = OP_SUB;
      K_MUL:   key_op = OP_MUL;
      default: key_op = OP_ADD;
    endcase
    a_app  = append_digit(a_mag_q, dig);
    b_app  = append_digit(b_mag_q, dig);
    result = alu(op_q, apply_sign(a_mag_q, a_neg_q), apply_sign(b_mag_q, b_neg_q));
  end

  // key_read marks the current press as consumed until the front end releases it.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      gst_q      <= ENTER_A;
      op_q       <= OP_ADD;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      a_dig_q    <= 1'b0;
      b_dig_q    <= 1'b0;
      key_read   <= 1'b0;
      display_q  <= '0;
      complete_q <= 1'b0;
    end else if (!key_valid_i) begin
      key_read <= 1'b0;
    end else if (!key_read) begin
      key_read <= 1'b1;
      if (key_i == K_CLR) begin
        gst_q      <= ENTER_A;
        op_q       <= OP_ADD;
        a_mag_q    <= '0;
        b_mag_q    <= '0;
        a_neg_q    <= 1'b0;
        b_neg_q    <= 1'b0;
        a_dig_q    <= 1'b0;
        b_dig_q    <= 1'b0;
        display_q  <= '0;
        complete_q <= 1'b0;
      end else begin
        case (gst_q)
          ENTER_A: begin
            if (is_dig) begin
              a_mag_q   <= a_app;
              a_dig_q   <= 1'b1;
              display_q <= apply_sign(a_app, a_neg_q);
            end else if (key_i == K_NEG && !a_dig_q) begin
              a_neg_q   <= 1'b1;
              display_q <= '0;
            end else if (is_op) begin
              op_q    <= key_op;
              gst_q   <= ENTER_B;
              b_mag_q <= '0;
              b_neg_q <= 1'b0;
              b_dig_q <= 1'b0;
            end
          end
          ENTER_B: begin
            if (is_dig) begin
              b_mag_q   <= b_app;
              b_dig_q   <= 1'b1;
              display_q <= apply_sign(b_app, b_neg_q);
            end else if (key_i == K_NEG && !b_dig_q) begin
              b_neg_q   <= 1'b1;
              display_q <= '0;
            end else if (is_op && !b_dig_q) begin
              op_q <= key_op;
            end else if (key_i == K_EQ) begin
              display_q  <= result;
              complete_q <= 1'b1;
              gst_q      <= DONE;
            end
          end
          DONE: begin
            if (is_dig || key_i == K_NEG) begin
              gst_q      <= ENTER_A;
              op_q       <= OP_ADD;
              complete_q <= 1'b0;
              a_mag_q    <= is_dig ? DATA_W'(dig) : '0;
              a_neg_q    <= !is_dig;
              a_dig_q    <= is_dig;
              display_q  <= is_dig ? DATA_W'(dig) : '0;
              b_mag_q    <= '0;
              b_neg_q    <= 1'b0;
              b_dig_q    <= 1'b0;
            end else if (is_op) begin
              gst_q      <= ENTER_B;
              op_q       <= key_op;
              complete_q <= 1'b0;
              a_mag_q    <= display_q;
              a_neg_q    <= 1'b0;
              a_dig_q    <= 1'b1;
              b_mag_q    <= '0;
              b_neg_q    <= 1'b0;
              b_dig_q    <= 1'b0;
            end
          end
          default: gst_q <= ENTER_A;
        endcase
      end
    end
  end

  assign display_o  = display_q;
  assign complete_o = complete_q;
endmodule

module keypad_calculator_top #(
  parameter int SCAN_HOLD = 4,
  parameter int DEBOUNCE  = 2
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [3:0]  RowIn,
  output logic [3:0]  ColOut,
  output logic [15:0] display_output,
  output logic        complete
);
  logic       key_valid;
  logic [3:0] key_idx;

  keypad_input_ctrl #(
    .SCAN_HOLD (SCAN_HOLD),
    .DEBOUNCE  (DEBOUNCE)
  ) input_ctrl_inst (
    .clk         (clk),
    .nRST        (nRST),
    .row_i       (RowIn),
    .col_o       (ColOut),
    .key_valid_o (key_valid),
    .key_o       (key_idx)
  );

  keypad_gencon #(
    .DATA_W (16)
  ) gencon_inst (
    .clk         (clk),
    .nRST        (nRST),
    .key_valid_i (key_valid),
    .key_i       (key_idx),
    .display_o   (display_output),
    .complete_o  (complete)
  );
endmodule

// File: tb/tb_keypad_calculator_top.sv
// Bench for keypad_calculator_top: a simulated key matrix presses keys and a
// calculator model predicts display/complete between presses.

module tb_keypad_calculator_top;
  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [3:0]  RowIn;
  logic [3:0]  ColOut;
  logic [15:0] display_output;
  logic        complete;

  logic        key_down = 1'b0;
  logic [3:0]  press_idx = 4'd0;
  logic [3:0]  row_force = 4'hF;
  logic        chk_en = 1'b0;

  int total = 0;
  int bad = 0;

  localparam int ADD = 3, SUB = 7, MUL = 11, EQ = 12, CLR = 14, NEG = 15;
  localparam int K1 = 0, K2 = 1, K3 = 2, K4 = 4, K5 = 5, K7 = 8, K9 = 10;

  keypad_calculator_top #(.SCAN_HOLD(4), .DEBOUNCE(2)) dut (
    .clk            (clk),
    .nRST           (nRST),
    .RowIn          (RowIn),
    .ColOut         (ColOut),
    .display_output (display_output),
    .complete       (complete)
  );

  always #5 clk = ~clk;

  // Key matrix: the pressed switch shorts its row to its column when that column is driven low.
  always_comb begin
    logic [3:0] rv;
    rv = 4'hF;
    if (key_down && ColOut[press_idx[1:0]] == 1'b0) rv[press_idx[3:2]] = 1'b0;
    RowIn = rv & row_force;
  end

  // Calculator model: operand magnitudes with sign flags, plain integer arithmetic.
  int          dmap [16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};
  int          m_stage, m_op;
  int unsigned m_a, m_b, m_disp;
  bit          m_an, m_bn, m_ad, m_bd, m_comp;

  function automatic int unsigned sval(input bit n, input int unsigned mag);
    return n ? ((32'h10000 - mag) & 32'hFFFF) : mag;
  endfunction

  task automatic model_clear();
    m_stage = 0; m_op = 0; m_a = 0; m_b = 0; m_an = 0; m_bn = 0;
    m_ad = 0; m_bd = 0; m_disp = 0; m_comp = 0;
  endtask

  task automatic model_apply(input int k);
    int d;
    int opk;
    longint av, bv, r;
    d = dmap[k];
    opk = (k == ADD) ? 0 : (k == SUB) ? 1 : (k == MUL) ? 2 : -1;
    if (k == CLR) begin
      model_clear();
      return;
    end
    if (m_stage == 2) begin
      if (d >= 0 || k == NEG) begin
        model_clear();
      end else if (opk >= 0) begin
        m_a = m_disp; m_an = 0; m_ad = 1; m_op = opk;
        m_b = 0; m_bn = 0; m_bd = 0; m_stage = 1; m_comp = 0;
        return;
      end else begin
        return;
      end
    end
    if (m_stage == 0) begin
      if (d >= 0) begin
        m_a = (m_a * 10 + d) % 65536; m_ad = 1; m_disp = sval(m_an, m_a);
      end else if (k == NEG && !m_ad) begin
        m_an = 1; m_disp = 0;
      end else if (opk >= 0) begin
        m_op = opk; m_stage = 1; m_b = 0; m_bn = 0; m_bd = 0;
      end
    end else begin
      if (d >= 0) begin
        m_b = (m_b * 10 + d) % 65536; m_bd = 1; m_disp = sval(m_bn, m_b);
      end else if (k == NEG && !m_bd) begin
        m_bn = 1; m_disp = 0;
      end else if (opk >= 0 && !m_bd) begin
        m_op = opk;
      end else if (k == EQ) begin
        av = longint'(sval(m_an, m_a));
        bv = longint'(sval(m_bn, m_b));
        r = (m_op == 0) ? av + bv : (m_op == 1) ? av - bv : av * bv;
        m_disp = int'(r & 64'hFFFF);
        m_comp = 1;
        m_stage = 2;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (display_output !== 16'(m_disp) || complete !== m_comp) begin
        bad++;
        $display("FAIL model_cmp t=%0t: display=%h complete=%b, expected display=%h complete=%b",
                 $time, display_output, complete, 16'(m_disp), m_comp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int max, input string name);
    int n;
    n = 0;
    while (dut.input_ctrl_inst.state != tgt && n < max) begin
      tick();
      n++;
    end
    chk(name, 32'(dut.input_ctrl_inst.state), 32'(tgt));
  endtask

  task automatic press(input int k);
    chk_en = 1'b0;
    press_idx = 4'(k);
    key_down = 1'b1;
    wait_state(2'd3, 200, "press_reach_held");
    repeat (2 + $urandom_range(0, 3)) tick();
    key_down = 1'b0;
    wait_state(2'd0, 20, "press_release");
    repeat (2) tick();
    model_apply(k);
    chk_en = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c0;
    int n;
    model_clear();
    nRST = 1'b0;
    repeat (3) tick();
    chk("reset_colout", 32'(ColOut), 32'h0000_000E);
    chk("reset_display", 32'(display_output), 32'h0);
    chk("reset_complete", 32'(complete), 32'h0);
    chk("reset_state", 32'(dut.input_ctrl_inst.state), 32'h0);
    chk("reset_keyread", 32'(dut.gencon_inst.key_read), 32'h0);
    nRST = 1'b1;
    chk_en = 1'b1;
    tick();

    press(CLR); press(NEG); press(K3); press(MUL); press(NEG); press(K4); press(EQ);
    chk("neg3_mul_neg4", 32'(display_output), 32'd12);
    chk("neg3_mul_neg4_cmpl", 32'(complete), 32'd1);
    chk("model_pin_12", m_disp, 32'd12);

    press(CLR); press(K3); press(MUL); press(K4); press(EQ);
    chk("3_mul_4", 32'(display_output), 32'd12);
    press(CLR); press(K3); press(ADD); press(K4); press(EQ);
    chk("3_add_4", 32'(display_output), 32'd7);
    chk("model_pin_7", m_disp, 32'd7);
    press(CLR); press(K5); press(SUB); press(K4); press(EQ);
    chk("5_sub_4", 32'(display_output), 32'd1);
    press(CLR); press(NEG); press(K5); press(SUB); press(K4); press(EQ);
    chk("neg5_sub_4", 32'(display_output), 32'hFFF7);
    chk("model_pin_fff7", m_disp, 32'hFFF7);

    press(CLR); press(K2); press(K5); press(MUL); press(K3); press(CLR);
    chk("clear_display", 32'(display_output), 32'd0);
    chk("clear_complete", 32'(complete), 32'd0);
    press(K9); press(ADD); press(K1); press(EQ);
    chk("9_add_1", 32'(display_output), 32'd10);
    chk("9_add_1_cmpl", 32'(complete), 32'd1);

    // Long hold: one digit only, key_read stays high throughout.
    press(CLR);
    chk_en = 1'b0;
    press_idx = 4'(K7);
    key_down = 1'b1;
    wait_state(2'd3, 200, "hold_reach_held");
    tick();
    for (int i = 0; i < 50; i++) begin
      chk("hold_state", 32'(dut.input_ctrl_inst.state), 32'd3);
      chk("hold_keyread", 32'(dut.gencon_inst.key_read), 32'd1);
      tick();
    end
    key_down = 1'b0;
    wait_state(2'd0, 20, "hold_release");
    repeat (2) tick();
    chk("hold_keyread_clear", 32'(dut.gencon_inst.key_read), 32'd0);
    model_apply(K7);
    chk("hold_single_digit", 32'(display_output), 32'd7);
    chk("model_pin_hold", m_disp, 32'd7);
    chk_en = 1'b1;

    // Single-clock row glitch with no key pressed.
    tick();
    row_force = 4'b1110;
    tick();
    chk("glitch_seen", 32'(dut.input_ctrl_inst.state), 32'd1);
    row_force = 4'hF;
    tick();
    chk("glitch_dropped", 32'(dut.input_ctrl_inst.state), 32'd0);
    c0 = ColOut;
    n = 0;
    while (ColOut == c0 && n < 12) begin
      tick();
      n++;
    end
    chk("glitch_scan_resumes", 32'(ColOut != c0), 32'd1);
    chk("glitch_no_key", 32'(display_output), 32'd7);

    // Randomized key sequence checked cycle by cycle against the model.
    for (int i = 0; i < 250; i++) begin
      press(int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 8)) tick();
    end

    // Reset while a key is being debounced.
    press(K5);
    chk_en = 1'b0;
    press_idx = 4'(K9);
    key_down = 1'b1;
    wait_state(2'd1, 200, "midreset_debounce");
    nRST = 1'b0;
    key_down = 1'b0;
    tick();
    chk("midreset_colout", 32'(ColOut), 32'h0000_000E);
    chk("midreset_state", 32'(dut.input_ctrl_inst.state), 32'd0);
    chk("midreset_display", 32'(display_output), 32'd0);
    chk("midreset_complete", 32'(complete), 32'd0);
    nRST = 1'b1;
    model_clear();
    chk_en = 1'b1;
    repeat (20) tick();
    chk("midreset_no_key", 32'(display_output), 32'd0);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
